risc_controller: RTL and testbench

- Sequencing front end of the Simple RISC Machine; sits directly upstream of the datapath.
- Holds PC, instruction register (IR) and data-address register.
- Decodes the 16-bit instruction and runs a multicycle FSM that drives every datapath control/select input and the memory command bus.
- Resolves branches (B, BEQ, BNE, BLT, BLE, BL, BX, BLX) from the datapath Z/N/V status outputs.

---
 rtl/risc_pkg.sv | 60 ++++++
 rtl/risc_controller_if.sv | 12 +
 rtl/instr_decoder.sv | 42 ++++
 rtl/risc_controller.sv | 185 ++++++++++++++++++
 tb/tb_risc_controller.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and encodings for the SRM sequencing controller
package risc_pkg;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
        S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG,
        S_ADDR, S_LD_ADDR, S_MEM_RD, S_WB, S_MOVE, S_MEM_WR,
        S_BR, S_BL_WR, S_BX_RD, S_BX_PC, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        NSEL_RN = 2'b00,
        NSEL_RD = 2'b01,
        NSEL_RM = 2'b10
    } nsel_t;

    localparam logic [2:0] OPC_BR  = 3'b001;
    localparam logic [2:0] OPC_BL  = 3'b010;
    localparam logic [2:0] OPC_LDR = 3'b011;
    localparam logic [2:0] OPC_STR = 3'b100;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MEM     = 2'b00;
    localparam logic [1:0] OP_COND_BR = 2'b00;
    localparam logic [1:0] OP_BX      = 2'b00;
    localparam logic [1:0] OP_BLX     = 2'b10;
    localparam logic [1:0] OP_BL      = 2'b11;

    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    function automatic logic cond_taken(input logic [2:0] cond,
                                        input logic z, input logic n, input logic v);
        case (cond)
            COND_B:   cond_taken = 1'b1;
            COND_BEQ: cond_taken = z;
            COND_BNE: cond_taken = ~z;
            COND_BLT: cond_taken = n ^ v;
            COND_BLE: cond_taken = (n ^ v) | z;
            default:  cond_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/risc_controller_if.sv
// rtl/risc_controller_if.sv - instruction/data memory command bus
interface risc_controller_if #(
    parameter int data_width = 16,
    parameter int pc_width   = 9
);
    logic [1:0]            mem_cmd;
    logic [pc_width-1:0]   mem_addr;
    logic [data_width-1:0] read_data;

    modport master (output mem_cmd, output mem_addr, input read_data);
    modport slave  (input mem_cmd, input mem_addr, output read_data);
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational field extraction and register select mux
module instr_decoder
    import risc_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic [data_width-1:0] ir,
    input  nsel_t                 nsel,
    output logic [2:0]            opcode,
    output logic [1:0]            op,
    output logic [2:0]            cond,
    output logic [data_width-1:0] sximm5,
    output logic [data_width-1:0] sximm8,
    output logic [1:0]            ALUop,
    output logic [1:0]            shift,
    output logic [2:0]            readnum,
    output logic [2:0]            writenum
);
    logic [2:0] reg_sel;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign cond   = ir[10:8];
    assign ALUop  = ir[12:11];
    assign sximm5 = {{(data_width-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(data_width-8){ir[7]}}, ir[7:0]};

    // Memory ops reuse IR[4:3] as offset bits, so the shifter must stay idle.
    assign shift = (opcode == OPC_LDR || opcode == OPC_STR) ? 2'b00 : ir[4:3];

    always_comb begin
        reg_sel = ir[10:8];
        case (nsel)
            NSEL_RD: reg_sel = ir[7:5];
            NSEL_RM: reg_sel = ir[2:0];
            default: reg_sel = ir[10:8];
        endcase
    end

    assign readnum  = reg_sel;
    assign writenum = reg_sel;
endmodule

// File: rtl/risc_controller.sv
// rtl/risc_controller.sv - multicycle fetch/decode/execute sequencer for the SRM datapath
module risc_controller
    import risc_pkg::*;
#(
    parameter int data_width = 16,
    parameter int pc_width   = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    risc_controller_if.master     mem,
    input  logic [data_width-1:0] regfile_out,
    input  logic [data_width-1:0] datapath_out,
    input  logic                  Z_out,
    input  logic                  N_out,
    input  logic                  V_out,
    output logic [pc_width-1:0]   PC,
    output logic [data_width-1:0] sximm5,
    output logic [data_width-1:0] sximm8,
    output logic [2:0]            readnum,
    output logic [2:0]            writenum,
    output logic [1:0]            ALUop,
    output logic [1:0]            shift,
    output logic                  write,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic [1:0]            vsel,
    output logic                  halted
);
    state_t                state, next_state;
    nsel_t                 nsel;
    logic [data_width-1:0] ir;
    logic [pc_width-1:0]   pc_reg;
    logic [pc_width-1:0]   data_addr;
    logic [2:0]            opcode, cond;
    logic [1:0]            op;
    logic                  taken;
    logic                  unused_hi;

    instr_decoder #(.data_width(data_width)) u_decoder (
        .ir       (ir),
        .nsel     (nsel),
        .opcode   (opcode),
        .op       (op),
        .cond     (cond),
        .sximm5   (sximm5),
        .sximm8   (sximm8),
        .ALUop    (ALUop),
        .shift    (shift),
        .readnum  (readnum),
        .writenum (writenum)
    );

    // BL shares the BR state but its cond field holds R7, so it is always taken.
    assign taken     = (opcode == OPC_BL) || cond_taken(cond, Z_out, N_out, V_out);
    assign PC        = pc_reg;
    assign unused_hi = ^{datapath_out[data_width-1:pc_width], regfile_out[data_width-1:pc_width]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RST;
        else          state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg    <= '0;
            ir        <= '0;
            data_addr <= '0;
        end else begin
            case (state)
                S_IF2:       ir        <= mem.read_data;
                S_UPDATE_PC: pc_reg    <= pc_reg + {{(pc_width-1){1'b0}}, 1'b1};
                S_LD_ADDR:   data_addr <= datapath_out[pc_width-1:0];
                S_BR:        if (taken) pc_reg <= pc_reg + sximm8[pc_width-1:0];
                S_BX_PC:     pc_reg    <= regfile_out[pc_width-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = S_HALT;
        case (state)
            S_RST:       next_state = S_IF1;
            S_IF1:       next_state = S_IF2;
            S_IF2:       next_state = S_UPDATE_PC;
            S_UPDATE_PC: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_MOV: if (op == OP_MOV_IMM)      next_state = S_WRITE_IMM;
                             else if (op == OP_MOV_REG) next_state = S_GET_B;
                    OPC_ALU: next_state = S_GET_A;
                    OPC_LDR, OPC_STR: if (op == OP_MEM) next_state = S_GET_A;
                    OPC_BR:  if (op == OP_COND_BR)      next_state = S_BR;
                    OPC_BL:  if (op == OP_BL || op == OP_BLX) next_state = S_BL_WR;
                             else if (op == OP_BX)           next_state = S_BX_RD;
                    default: next_state = S_HALT;
                endcase
            end
            S_GET_A:     next_state = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
            S_GET_B:     next_state = (opcode == OPC_STR) ? S_MOVE : S_EXEC;
            S_EXEC:      next_state = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WRITE_REG;
            S_ADDR:      next_state = S_LD_ADDR;
            S_LD_ADDR:   next_state = (opcode == OPC_LDR) ? S_MEM_RD : S_GET_B;
            S_MEM_RD:    next_state = S_WB;
            S_MOVE:      next_state = S_MEM_WR;
            S_BL_WR:     next_state = (op == OP_BL) ? S_BR : S_BX_RD;
            S_BX_RD:     next_state = S_BX_PC;
            S_HALT:      next_state = S_HALT;
            S_WRITE_IMM, S_WRITE_REG, S_WB, S_MEM_WR, S_BR, S_BX_PC:
                         next_state = S_IF1;
            default:     next_state = S_RST;
        endcase
    end

    always_comb begin
        mem.mem_cmd  = MEM_NONE;
        mem.mem_addr = pc_reg;
        nsel         = NSEL_RN;
        write        = 1'b0;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        vsel         = VSEL_C;
        halted       = 1'b0;
        case (state)
            S_IF1, S_IF2: mem.mem_cmd = MEM_RD;
            S_WRITE_IMM: begin
                write = 1'b1;
                vsel  = VSEL_IMM;
            end
            S_GET_A: loada = 1'b1;
            S_GET_B: begin
                loadb = 1'b1;
                nsel  = (opcode == OPC_STR) ? NSEL_RD : NSEL_RM;
            end
            S_EXEC: begin
                loadc = 1'b1;
                asel  = (opcode == OPC_MOV);
                loads = (opcode == OPC_ALU) && (op == OP_CMP);
            end
            S_WRITE_REG: begin
                write = 1'b1;
                nsel  = NSEL_RD;
            end
            S_ADDR: begin
                loadc = 1'b1;
                bsel  = 1'b1;
            end
            S_MEM_RD: begin
                mem.mem_cmd  = MEM_RD;
                mem.mem_addr = data_addr;
            end
            // Read stays asserted so mdata is still driven while it is written back.
            S_WB: begin
                mem.mem_cmd  = MEM_RD;
                mem.mem_addr = data_addr;
                write        = 1'b1;
                vsel         = VSEL_MDATA;
                nsel         = NSEL_RD;
            end
            S_MOVE: begin
                loadc = 1'b1;
                asel  = 1'b1;
            end
            S_MEM_WR: begin
                mem.mem_cmd  = MEM_WR;
                mem.mem_addr = data_addr;
            end
            S_BL_WR: begin
                write = 1'b1;
                vsel  = VSEL_PC;
            end
            S_BX_RD, S_BX_PC: nsel = NSEL_RD;
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_risc_controller.sv
// tb/tb_risc_controller.sv - scoreboard bench for risc_controller
module tb_risc_controller;
    localparam logic [7:0] W  = 8'h80, LA = 8'h40, LB = 8'h20, LC = 8'h10;
    localparam logic [7:0] LS = 8'h08, AS = 8'h04, BS = 8'h02, HL = 8'h01;

    typedef struct {
        int         mc;
        int         ma;
        int         pc;
        logic [7:0] st;
        int         vs;
        int         rn;
        string      nm;
    } exp_t;

    typedef struct {
        string       nm;
        logic [15:0] instr;
        logic        z;
        logic        n;
        logic        v;
        int          target;
    } br_vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] regfile_out, datapath_out;
    logic        Z_out, N_out, V_out;
    logic [8:0]  PC;
    logic [15:0] sximm5, sximm8;
    logic [2:0]  readnum, writenum;
    logic [1:0]  ALUop, shift, vsel;
    logic        write, loada, loadb, loadc, loads, asel, bsel, halted;
    logic        unused_tb;
    logic [15:0] mem [0:511];

    exp_t    q[$];
    br_vec_t bv[11];
    int      total = 0;
    int      bad = 0;

    risc_controller_if #(.data_width(16), .pc_width(9)) bus ();

    assign bus.read_data = mem[bus.mem_addr];
    assign unused_tb = ^{sximm5, sximm8, ALUop, shift};

    risc_controller #(.data_width(16), .pc_width(9)) dut (
        .clk(clk), .reset_n(reset_n), .mem(bus),
        .regfile_out(regfile_out), .datapath_out(datapath_out),
        .Z_out(Z_out), .N_out(N_out), .V_out(V_out),
        .PC(PC), .sximm5(sximm5), .sximm8(sximm8),
        .readnum(readnum), .writenum(writenum), .ALUop(ALUop), .shift(shift),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        logic [7:0] st;
        logic       ok;
        st = {write, loada, loadb, loadc, loads, asel, bsel, halted};
        ok = 1'b1;
        if (e.mc >= 0 && int'(bus.mem_cmd) != e.mc) ok = 1'b0;
        if (e.ma >= 0 && int'(bus.mem_addr) != e.ma) ok = 1'b0;
        if (e.pc >= 0 && int'(PC) != e.pc) ok = 1'b0;
        if (st != e.st) ok = 1'b0;
        if (e.vs >= 0 && int'(vsel) != e.vs) ok = 1'b0;
        if (e.rn >= 0 && (int'(readnum) != e.rn || int'(writenum) != e.rn)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got mc=%0d ma=%0d pc=%0d st=%b vs=%0d rn=%0d/%0d want mc=%0d ma=%0d pc=%0d st=%b vs=%0d rn=%0d",
                     e.nm, bus.mem_cmd, bus.mem_addr, PC, st, vsel, readnum, writenum,
                     e.mc, e.ma, e.pc, e.st, e.vs, e.rn);
        end
    endtask

    task automatic push(input int mc, input int ma, input int pc, input logic [7:0] st,
                        input int vs, input int rn, input string nm);
        exp_t e;
        e = '{mc, ma, pc, st, vs, rn, nm};
        q.push_back(e);
    endtask

    task automatic fetch(input int a);
        push(1, a, a, 8'h00, -1, -1, "if1");
        push(1, a, a, 8'h00, -1, -1, "if2");
        push(0, -1, a, 8'h00, -1, -1, "update_pc");
        push(0, -1, (a + 1) % 512, 8'h00, -1, -1, "decode");
    endtask

    task automatic halt_recs(input int p, input int n);
        for (int i = 0; i < n; i++) push(0, -1, p, HL, -1, -1, "halt");
    endtask

    // Reset lands mid-cycle wherever the previous sequence stopped.
    task automatic begin_test(input logic z, input logic n, input logic v,
                              input logic [15:0] rf, input logic [15:0] dp);
        exp_t e;
        #2 reset_n = 1'b0;
        #1;
        e = '{0, -1, 0, 8'h00, -1, -1, "reset"};
        check(e);
        Z_out = z; N_out = n; V_out = v;
        regfile_out = rf; datapath_out = dp;
        for (int i = 0; i < 512; i++) mem[i] = 16'hE000;
        push(0, -1, 0, 8'h00, -1, -1, "rst_state");
    endtask

    task automatic drain();
        exp_t e;
        @(negedge clk);
        reset_n = 1'b1;
        e = q.pop_front();
        check(e);
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            check(e);
        end
    endtask

    initial begin
        bv[0]  = '{"beq_t",   16'h2103, 1'b1, 1'b0, 1'b0, 8};
        bv[1]  = '{"beq_nt",  16'h2103, 1'b0, 1'b0, 1'b0, 5};
        bv[2]  = '{"bne_t",   16'h2203, 1'b0, 1'b0, 1'b0, 8};
        bv[3]  = '{"bne_nt",  16'h2203, 1'b1, 1'b0, 1'b0, 5};
        bv[4]  = '{"blt_t",   16'h2303, 1'b0, 1'b1, 1'b0, 8};
        bv[5]  = '{"blt_nt",  16'h2303, 1'b0, 1'b1, 1'b1, 5};
        bv[6]  = '{"ble_z",   16'h2403, 1'b1, 1'b0, 1'b0, 8};
        bv[7]  = '{"ble_nv",  16'h2403, 1'b0, 1'b0, 1'b1, 8};
        bv[8]  = '{"ble_nt",  16'h2403, 1'b0, 1'b0, 1'b0, 5};
        bv[9]  = '{"cond101", 16'h2503, 1'b1, 1'b1, 1'b0, 5};
        bv[10] = '{"b_back",  16'h20FD, 1'b0, 1'b0, 1'b0, 2};

        // MOV imm, CMP, MOV reg, ADD, HALT
        begin_test(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        mem[0] = 16'hD107; mem[1] = 16'hA902; mem[2] = 16'hC061; mem[3] = 16'hA143;
        fetch(0);
        push(0, -1, 1, W, 2, 1, "mov_imm_wr");
        fetch(1);
        push(0, -1, 2, LA, -1, 1, "cmp_get_a");
        push(0, -1, 2, LB, -1, 2, "cmp_get_b");
        push(0, -1, 2, LC | LS, -1, -1, "cmp_exec");
        fetch(2);
        push(0, -1, 3, LB, -1, 1, "movr_get_b");
        push(0, -1, 3, LC | AS, -1, -1, "movr_exec");
        push(0, -1, 3, W, 0, 3, "movr_wr");
        fetch(3);
        push(0, -1, 4, LA, -1, 1, "add_get_a");
        push(0, -1, 4, LB, -1, 3, "add_get_b");
        push(0, -1, 4, LC, -1, -1, "add_exec");
        push(0, -1, 4, W, 0, 2, "add_wr");
        fetch(4);
        halt_recs(5, 3);
        drain();

        for (int i = 0; i < 11; i++) begin
            begin_test(bv[i].z, bv[i].n, bv[i].v, 16'd0, 16'd0);
            mem[0] = 16'h2003;
            mem[4] = bv[i].instr;
            fetch(0);
            push(0, -1, 1, 8'h00, -1, -1, "b_to_4");
            fetch(4);
            push(0, -1, 5, 8'h00, -1, -1, {bv[i].nm, "_br"});
            fetch(bv[i].target);
            halt_recs(bv[i].target + 1, 2);
            drain();
        end

        // BL, BX R7, BLX R7
        begin_test(1'b0, 1'b0, 1'b0, 16'd11, 16'd0);
        mem[0] = 16'h2009; mem[10] = 16'h5FFD; mem[8] = 16'h40E0; mem[11] = 16'h57E0;
        fetch(0);
        push(0, -1, 1, 8'h00, -1, -1, "b_to_10");
        fetch(10);
        push(0, -1, 11, W, 1, 7, "bl_wr");
        push(0, -1, 11, 8'h00, -1, -1, "bl_br");
        fetch(8);
        push(0, -1, 9, 8'h00, -1, 7, "bx_rd");
        push(0, -1, 9, 8'h00, -1, -1, "bx_pc");
        fetch(11);
        push(0, -1, 12, W, 1, 7, "blx_wr");
        push(0, -1, 12, 8'h00, -1, 7, "blx_rd");
        push(0, -1, 12, 8'h00, -1, -1, "blx_pc");
        fetch(11);
        drain();

        // LDR R1,[R0,#1] then STR R1,[R0,#1] with R0+1 = 21 on the C bus
        begin_test(1'b0, 1'b0, 1'b0, 16'd0, 16'd21);
        mem[0] = 16'h6021; mem[1] = 16'h8021;
        fetch(0);
        push(0, -1, 1, LA, -1, 0, "ldr_get_a");
        push(0, -1, 1, LC | BS, -1, -1, "ldr_addr");
        push(0, -1, 1, 8'h00, -1, -1, "ldr_ld_addr");
        push(1, 21, 1, 8'h00, -1, -1, "ldr_mem_rd");
        push(-1, -1, 1, W, 3, 1, "ldr_wb");
        fetch(1);
        push(0, -1, 2, LA, -1, 0, "str_get_a");
        push(0, -1, 2, LC | BS, -1, -1, "str_addr");
        push(0, -1, 2, 8'h00, -1, -1, "str_ld_addr");
        push(0, -1, 2, LB, -1, 1, "str_get_b");
        push(0, -1, 2, LC | AS, -1, -1, "str_move");
        push(2, 21, 2, 8'h00, -1, -1, "str_mem_wr");
        fetch(2);
        halt_recs(3, 2);
        drain();

        // PC wrap 511 -> 0, then a long halt
        begin_test(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        mem[0] = 16'h20FE;
        fetch(0);
        push(0, -1, 1, 8'h00, -1, -1, "b_to_511");
        fetch(511);
        halt_recs(0, 20);
        drain();

        // Stop inside WRITE_IMM; the next reset check must see write drop at once
        begin_test(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        mem[0] = 16'hD107;
        fetch(0);
        push(0, -1, 1, W, 2, 1, "abort_wr");
        drain();
        begin_test(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        fetch(0);
        halt_recs(1, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
